// File: rtl/irrigation_pkg.sv
// irrigation_pkg: shared types and constants for the irrigation timing blocks.
//   timer_state_t  - countdown timer FSM states (IDLE, RUN, PAUSE, DONE)
//   BCD_MAX_UNITS  - largest legal BCD digit value (9)
//   BCD_ZERO       - BCD zero digit
//   digit_legal()  - true when a digit does not exceed a given maximum
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_ZERO      = 4'd0;

  function automatic logic digit_legal(input logic [3:0] d, input logic [3:0] max_d);
    return d <= max_d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit with parallel load and enabled decrement.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (digit clears to 0)
//   load        - load load_val (has priority over decrement)
//   load_val    - value to load
//   dec_en      - decrement by one; 0 wraps to 9
//   digit       - current digit value
//   borrow      - high when a decrement is enabled while the digit is 0
//                 (chains into the next-higher digit's dec_en)
//   zero        - digit equals 0
module bcd_digit_dec
  import irrigation_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] digit,
  output logic       borrow,
  output logic       zero
);

  assign zero   = (digit == BCD_ZERO);
  assign borrow = dec_en && zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_en) begin
      digit <= zero ? BCD_MAX_UNITS : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: two-digit BCD down-counter timing one irrigation
// interval. Loaded with a preset, decrements once per tick while the valve is
// open, pauses on humidity hold (us) or supply alarm (alin), reports expiry.
// Optional feature macro: AUTO_RELOAD_EN - on expiry reload the count from the
// stored preset and keep running until stop.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   tick                       - 1 Hz one-cycle enable
//   load, preset_tens/units    - preset load request and BCD digits
//   start, stop                - begin counting / abort to IDLE keeping count
//   us, alin                   - pause requests (either one pauses)
//   tens, units                - current count digits
//   valve_on                   - high in RUN
//   paused                     - high in PAUSE
//   done                       - one-cycle pulse on expiry
//   load_err                   - one-cycle pulse on a rejected load
module bcd_countdown_timer
  import irrigation_pkg::*;
#(
  parameter int MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_units,
  input  logic       start,
  input  logic       stop,
  input  logic       us,
  input  logic       alin,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       valve_on,
  output logic       paused,
  output logic       done,
  output logic       load_err
);

  localparam logic [3:0] MAX_TENS_D = 4'(MAX_TENS);

  timer_state_t state, state_next;

  logic       units_zero, tens_zero;
  logic       units_borrow;
  // The FSM never decrements past 00, so the tens digit never borrows.
  logic       tens_borrow_unused;
  logic       digit_load;
  logic [3:0] load_tens, load_units;
  logic       dec_en;
  logic       accept_load;
  logic       done_next, load_err_next;
  logic       preset_ok, pause_req, count_one;

  assign preset_ok = digit_legal(preset_tens, MAX_TENS_D) &&
                     digit_legal(preset_units, BCD_MAX_UNITS);
  assign pause_req = us | alin;
  assign count_one = tens_zero && (units == 4'd1);

`ifdef AUTO_RELOAD_EN
  logic [3:0] preset_tens_q, preset_units_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preset_tens_q  <= BCD_ZERO;
      preset_units_q <= BCD_ZERO;
    end else if (accept_load) begin
      preset_tens_q  <= preset_tens;
      preset_units_q <= preset_units;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_next;
      done     <= done_next;
      load_err <= load_err_next;
    end
  end

  // Priority: stop, then load (IDLE/DONE only), then per-state behaviour.
  always_comb begin
    state_next    = state;
    digit_load    = 1'b0;
    load_tens     = preset_tens;
    load_units    = preset_units;
    dec_en        = 1'b0;
    accept_load   = 1'b0;
    done_next     = 1'b0;
    load_err_next = 1'b0;

    if (stop) begin
      state_next = IDLE;
    end else if (load && (state == IDLE || state == DONE)) begin
      if (preset_ok) begin
        accept_load = 1'b1;
        digit_load  = 1'b1;
        state_next  = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (tens_zero && units_zero) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          // A pause request wins over a coincident tick; that tick is lost.
          if (pause_req) begin
            state_next = PAUSE;
          end else if (tick && !(tens_zero && units_zero)) begin
            dec_en = 1'b1;
            if (count_one) begin
              done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
              digit_load = 1'b1;
              load_tens  = preset_tens_q;
              load_units = preset_units_q;
`else
              state_next = DONE;
`endif
            end
          end
        end
        PAUSE: begin
          if (!pause_req) state_next = RUN;
        end
        DONE: begin
        end
        default: state_next = IDLE;
      endcase
    end
  end

  bcd_digit_dec u_units (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (digit_load),
    .load_val (load_units),
    .dec_en   (dec_en),
    .digit    (units),
    .borrow   (units_borrow),
    .zero     (units_zero)
  );

  bcd_digit_dec u_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (digit_load),
    .load_val (load_tens),
    .dec_en   (units_borrow),
    .digit    (tens),
    .borrow   (tens_borrow_unused),
    .zero     (tens_zero)
  );

  // Decoded straight from the state register so reset drops them at once.
  assign valve_on = (state == RUN);
  assign paused   = (state == PAUSE);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: directed scenarios plus randomized
// stimulus, all compared against a seconds-valued behavioural model.
module tb_bcd_countdown_timer;

  localparam int MAXT = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, load, start, stop, us, alin;
  logic [3:0] preset_tens, preset_units;
  logic [3:0] tens, units;
  logic       valve_on, paused, done, load_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: state 0=idle 1=run 2=pause 3=done; count in seconds.
  int m_state, m_count, m_preset;
  bit m_done, m_err;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.MAX_TENS(MAXT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .load         (load),
    .preset_tens  (preset_tens),
    .preset_units (preset_units),
    .start        (start),
    .stop         (stop),
    .us           (us),
    .alin         (alin),
    .tens         (tens),
    .units        (units),
    .valve_on     (valve_on),
    .paused       (paused),
    .done         (done),
    .load_err     (load_err)
  );

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_preset = 0; m_done = 0; m_err = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle 1 time unit.
  task automatic step(input bit t, input bit l, input int pt, input int pu,
                      input bit s, input bit sp, input bit u, input bit a);
    tick = t; load = l; preset_tens = 4'(pt); preset_units = 4'(pu);
    start = s; stop = sp; us = u; alin = a;
    @(posedge clk);
    m_done = 0; m_err = 0;
    if (sp) begin
      m_state = 0;
    end else if (l && (m_state == 0 || m_state == 3)) begin
      if (pt <= MAXT && pu <= 9) begin
        m_count = pt * 10 + pu; m_preset = m_count; m_state = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      case (m_state)
        0: if (s) begin
             if (m_count == 0) begin m_state = 3; m_done = 1; end
             else m_state = 1;
           end
        1: if (u || a) m_state = 2;
           else if (t && m_count > 0) begin
             m_count = m_count - 1;
             if (m_count == 0) begin
               m_done = 1;
`ifdef AUTO_RELOAD_EN
               m_count = m_preset;
`else
               m_state = 3;
`endif
             end
           end
        2: if (!(u || a)) m_state = 1;
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick = 0; load = 0; preset_tens = 0; preset_units = 0;
    start = 0; stop = 0; us = 0; alin = 0;
    #12;
    n_tests++; if ({tens, units} !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", {tens, units}); end
    n_tests++; if (valve_on !== 1'b0) begin n_fail++; $display("FAIL reset_valve got=%b exp=0", valve_on); end
    n_tests++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused got=%b exp=0", paused); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_countdown();
    int e;
    step(0, 1, 2, 5, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h25) begin n_fail++; $display("FAIL cd_load got=%h exp=25", {tens, units}); end
    n_tests++; if (valve_on !== 1'b0) begin n_fail++; $display("FAIL cd_valve_idle got=%b exp=0", valve_on); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_tests++; if (valve_on !== 1'b1) begin n_fail++; $display("FAIL cd_start_valve got=%b exp=1", valve_on); end
    for (int i = 1; i <= 25; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      e = 25 - i;
      n_tests++; if ({tens, units} !== bcd8(e)) begin n_fail++; $display("FAIL cd_count got=%h exp=%h", {tens, units}, bcd8(e)); end
      n_tests++; if (valve_on !== (e != 0)) begin n_fail++; $display("FAIL cd_valve got=%b exp=%b", valve_on, (e != 0)); end
      n_tests++; if (done !== (e == 0)) begin n_fail++; $display("FAIL cd_done got=%b exp=%b", done, (e == 0)); end
      if (e != 0 && (i % 4) == 0) begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++; if ({tens, units} !== bcd8(e)) begin n_fail++; $display("FAIL cd_hold got=%h exp=%h", {tens, units}, bcd8(e)); end
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL cd_done_width got=%b exp=0", done); end
    n_tests++; if ({tens, units} !== 8'h00) begin n_fail++; $display("FAIL cd_hold00 got=%h exp=00", {tens, units}); end
  endtask

  task automatic test_pause();
    step(0, 1, 0, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h02) begin n_fail++; $display("FAIL pz_first got=%h exp=02", {tens, units}); end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 1);
      n_tests++; if ({tens, units} !== 8'h02) begin n_fail++; $display("FAIL pz_hold got=%h exp=02", {tens, units}); end
      n_tests++; if (paused !== 1'b1 || valve_on !== 1'b0) begin n_fail++; $display("FAIL pz_flags got=%b%b exp=10", paused, valve_on); end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (paused !== 1'b0 || valve_on !== 1'b1) begin n_fail++; $display("FAIL pz_resume got=%b%b exp=01", paused, valve_on); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h01 || done !== 1'b0) begin n_fail++; $display("FAIL pz_second got=%h/%b exp=01/0", {tens, units}, done); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h00 || done !== 1'b1) begin n_fail++; $display("FAIL pz_third got=%h/%b exp=00/1", {tens, units}, done); end
  endtask

  task automatic test_load_err();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 2, 0, 0, 0, 0);
    step(0, 1, 6, 0, 0, 0, 0, 0);
    n_tests++; if (load_err !== 1'b1 || {tens, units} !== 8'h12) begin n_fail++; $display("FAIL le_tens got=%b/%h exp=1/12", load_err, {tens, units}); end
    step(0, 1, 1, 10, 0, 0, 0, 0);
    n_tests++; if (load_err !== 1'b1 || {tens, units} !== 8'h12) begin n_fail++; $display("FAIL le_units got=%b/%h exp=1/12", load_err, {tens, units}); end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL le_width got=%b exp=0", load_err); end
    step(0, 1, 0, 0, 0, 0, 0, 0);
    n_tests++; if (load_err !== 1'b0 || {tens, units} !== 8'h00) begin n_fail++; $display("FAIL le_zero_load got=%b/%h exp=0/00", load_err, {tens, units}); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_tests++; if (done !== 1'b1 || valve_on !== 1'b0) begin n_fail++; $display("FAIL le_zero_start got=%b/%b exp=1/0", done, valve_on); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL le_done_start got=%b exp=0", done); end
  endtask

  task automatic test_stop_priority();
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h07) begin n_fail++; $display("FAIL sp_before got=%h exp=07", {tens, units}); end
    step(0, 1, 4, 4, 1, 1, 0, 0);
    n_tests++; if ({tens, units} !== 8'h07 || valve_on !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL sp_combo got=%h/%b/%b exp=07/0/0", {tens, units}, valve_on, load_err); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_tests++; if (valve_on !== 1'b1) begin n_fail++; $display("FAIL sp_resume got=%b exp=1", valve_on); end
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (done !== (i == 7)) begin n_fail++; $display("FAIL sp_done got=%b exp=%b", done, (i == 7)); end
    end
`ifdef AUTO_RELOAD_EN
    n_tests++; if ({tens, units} !== 8'h10 || valve_on !== 1'b1) begin n_fail++; $display("FAIL sp_reload got=%h/%b exp=10/1", {tens, units}, valve_on); end
`else
    n_tests++; if ({tens, units} !== 8'h00 || valve_on !== 1'b0) begin n_fail++; $display("FAIL sp_end got=%h/%b exp=00/0", {tens, units}, valve_on); end
`endif
    step(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h14) begin n_fail++; $display("FAIL ar_before got=%h exp=14", {tens, units}); end
    tick = 0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({tens, units} !== 8'h00 || valve_on !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_async got=%h/%b/%b exp=00/0/0", {tens, units}, valve_on, done); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if ({tens, units} !== 8'h00 || valve_on !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_after got=%h/%b/%b exp=00/0/0", {tens, units}, valve_on, done); end
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    step(0, 1, 0, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (done !== (i == 3 || i == 6)) begin n_fail++; $display("FAIL ap_done got=%b exp=%b", done, (i == 3 || i == 6)); end
      n_tests++; if (valve_on !== 1'b1) begin n_fail++; $display("FAIL ap_valve got=%b exp=1", valve_on); end
    end
    n_tests++; if ({tens, units} !== 8'h02) begin n_fail++; $display("FAIL ap_count got=%h exp=02", {tens, units}); end
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    n_tests++; if (done !== 1'b1 || valve_on !== 1'b0) begin n_fail++; $display("FAIL ap_zero got=%b/%b exp=1/0", done, valve_on); end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (done !== 1'b0 || valve_on !== 1'b0) begin n_fail++; $display("FAIL ap_zero_loop got=%b/%b exp=0/0", done, valve_on); end
  endtask
`endif

  task automatic test_random();
    bit t, l, s, sp, u, a;
    int pt, pu;
    for (int c = 0; c < 600; c++) begin
      t  = ($urandom_range(0, 1) == 0);
      l  = ($urandom_range(0, 11) == 0);
      s  = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 39) == 0);
      u  = ($urandom_range(0, 11) == 0);
      a  = ($urandom_range(0, 11) == 0);
      pt = $urandom_range(0, 7);
      pu = $urandom_range(0, 11);
      step(t, l, pt, pu, s, sp, u, a);
      n_tests++; if ({tens, units} !== bcd8(m_count)) begin n_fail++; $display("FAIL rnd_count c=%0d got=%h exp=%h", c, {tens, units}, bcd8(m_count)); end
      n_tests++; if (valve_on !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_valve c=%0d got=%b exp=%b", c, valve_on, (m_state == 1)); end
      n_tests++; if (paused !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_paused c=%0d got=%b exp=%b", c, paused, (m_state == 2)); end
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, done, m_done); end
      n_tests++; if (load_err !== m_err) begin n_fail++; $display("FAIL rnd_load_err c=%0d got=%b exp=%b", c, load_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_load_err();
    test_stop_priority();
    test_async_reset();
`ifdef AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
